// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package proc_pkg;

    localparam int          XLEN    = 32;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO between fetch and decode.
// Flush wins over push/pop. A push into a full queue is accepted only
// when a pop frees a slot in the same cycle. dout is the storage word at
// the read pointer, so it is a registered value with no path from pop.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);

    // Pointer and occupancy next-state; flush resets everything to empty.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (pop_ok) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push_ok) begin
                wptr_d = wptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are never observed while the slot is empty,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, combinational imem access,
// fetch/redirect control, enqueue counter, and the fetch queue toward
// decode. A redirect flushes the queue and reloads the PC; the head that
// decode accepts in that same cycle is still considered consumed.
module fetch_stage
    import proc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready,
    output logic [31:0] fetch_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    fetch_entry_t    q_din;
    fetch_entry_t    q_dout;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;

    logic            transfer;
    logic            do_fetch;
    logic            unused_bits;

    // Low redirect bits are dropped by construction; the queue's full flag
    // is redundant with the count compare used below.
    assign unused_bits = ^{redirect_pc[1:0], q_full};

    assign imem_addr = pc_q;

    assign transfer  = if_valid && id_ready;
    assign do_fetch  = fetch_en && !redirect_valid &&
                       ((q_count < CW'(DEPTH)) || transfer);

    assign q_din.pc    = pc_q;
    assign q_din.instr = imem_rdata;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (do_fetch),
        .pop   (transfer),
        .flush (redirect_valid),
        .din   (q_din),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // PC and enqueue-counter next state; redirect takes priority over fetch.
    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (do_fetch) begin
            pc_d          = pc_q + PC_STEP;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // PC and enqueue-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Decode-facing outputs: queue head, forced to zero when empty.
    always_comb begin
        if_valid    = !q_empty;
        if_instr    = '0;
        if_pc       = '0;
        if_pc_plus4 = '0;
        if (!q_empty) begin
            if_instr    = q_dout.instr;
            if_pc       = q_dout.pc;
            if_pc_plus4 = q_dout.pc + PC_STEP;
        end
    end

    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        id_ready;
    logic [31:0] fetch_count;

    logic        rst_hi;
    logic [31:0] imem_addr_hi;
    logic [31:0] imem_rdata_hi;
    logic        if_valid_hi;
    logic [31:0] if_instr_hi;
    logic [31:0] if_pc_hi;
    logic [31:0] if_pc_plus4_hi;
    logic [31:0] fetch_count_hi;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata    = mem_word(imem_addr);
    assign imem_rdata_hi = mem_word(imem_addr_hi);

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .id_ready       (id_ready),
        .fetch_count    (fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_hi (
        .clk            (clk),
        .rst_n          (rst_hi),
        .fetch_en       (1'b1),
        .imem_addr      (imem_addr_hi),
        .imem_rdata     (imem_rdata_hi),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (if_valid_hi),
        .if_instr       (if_instr_hi),
        .if_pc          (if_pc_hi),
        .if_pc_plus4    (if_pc_plus4_hi),
        .id_ready       (1'b1),
        .fetch_count    (fetch_count_hi)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Reference model: a plain queue of {pc, instr} plus PC and counter.
    localparam int MDEPTH = 2;
    logic [63:0] mq [$];
    logic [31:0] pc_m;
    logic [31:0] fc_m;

    task automatic model_reset();
        mq.delete();
        pc_m = 32'h0;
        fc_m = 32'h0;
    endtask

    task automatic model_step();
        bit xfer;
        bit fet;
        xfer = (mq.size() > 0) && id_ready;
        fet  = fetch_en && !redirect_valid && ((mq.size() < MDEPTH) || xfer);
        if (xfer) void'(mq.pop_front());
        if (redirect_valid) begin
            mq.delete();
            pc_m = redirect_pc & 32'hFFFF_FFFC;
        end else if (fet) begin
            mq.push_back({pc_m, mem_word(pc_m)});
            pc_m = pc_m + 32'd4;
            fc_m = fc_m + 32'd1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] h;
        logic [31:0] hp;
        h  = (mq.size() > 0) ? mq[0] : 64'h0;
        hp = h[63:32];
        check_val({tag, ".valid"}, {31'h0, if_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
        check_val({tag, ".pc"},    if_pc,    hp);
        check_val({tag, ".instr"}, if_instr, h[31:0]);
        check_val({tag, ".pc4"},   if_pc_plus4, (mq.size() > 0) ? hp + 32'd4 : 32'd0);
        check_val({tag, ".addr"},  imem_addr, pc_m);
        check_val({tag, ".fcnt"},  fetch_count, fc_m);
    endtask

    // Drive inputs at the falling edge, step model at rising edge, check at next falling edge.
    task automatic cycle(input logic fe, input logic rv, input logic [31:0] rpc,
                         input logic rdy, input string tag);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst_n          = 1'b0;
        rst_hi         = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        check_val("rst.valid", {31'h0, if_valid}, 32'd0);
        check_val("rst.pc",    if_pc, 32'h0);
        check_val("rst.instr", if_instr, 32'h0);
        check_val("rst.pc4",   if_pc_plus4, 32'h0);
        check_val("rst.addr",  imem_addr, 32'h0);
        check_val("rst.fcnt",  fetch_count, 32'h0);
        rst_n = 1'b1;

        // Free-running fetch from reset
        cycle(1, 0, 0, 1, "run0");
        check_val("run0.pc_k",    if_pc, 32'h0);
        check_val("run0.instr_k", if_instr, 32'hA5A5_0000);
        check_val("run0.pc4_k",   if_pc_plus4, 32'h4);
        for (int k = 1; k < 4; k++) begin
            cycle(1, 0, 0, 1, "run");
            check_val("run.pc_k", if_pc, 32'(k * 4));
        end

        // Back-pressure: id_ready low for 5 cycles after reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, "stall");
        check_val("stall.fcnt_k", fetch_count, 32'd2);
        check_val("stall.addr_k", imem_addr, 32'd8);
        check_val("stall.pc_k",   if_pc, 32'd0);
        for (int k = 1; k < 4; k++) begin
            cycle(1, 0, 0, 1, "drain");
            check_val("drain.pc_k", if_pc, 32'(k * 4));
        end

        // Redirect with two queued entries
        cycle(1, 1, 32'h0000_0103, 0, "redir");
        check_val("redir.valid_k", {31'h0, if_valid}, 32'd0);
        check_val("redir.addr_k",  imem_addr, 32'h100);
        cycle(1, 0, 0, 0, "redir1");
        check_val("redir1.pc_k", if_pc, 32'h100);

        // Redirect and transfer together at a full queue
        cycle(1, 0, 0, 0, "fill");
        cycle(1, 0, 0, 0, "fill");
        cycle(1, 1, 32'h0000_0200, 1, "rx");
        check_val("rx.valid_k", {31'h0, if_valid}, 32'd0);
        cycle(1, 0, 0, 1, "rx1");
        check_val("rx1.pc_k", if_pc, 32'h200);
        cycle(1, 0, 0, 1, "rx2");
        check_val("rx2.pc_k", if_pc, 32'h204);

        // fetch_en low: queue drains, PC holds
        cycle(0, 0, 0, 1, "halt");
        cycle(0, 0, 0, 1, "halt");
        cycle(0, 0, 0, 1, "halt");
        cycle(0, 1, 32'h0000_0404, 0, "halt_redir");

        // Mid-stream asynchronous reset with a full queue
        cycle(1, 0, 0, 0, "fill2");
        cycle(1, 0, 0, 0, "fill2");
        cycle(1, 0, 0, 0, "fill2");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("areset.valid", {31'h0, if_valid}, 32'd0);
        check_val("areset.addr",  imem_addr, 32'h0);
        check_val("areset.fcnt",  fetch_count, 32'h0);
        check_val("areset.pc",    if_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            cycle(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0),
                  rpc,
                  ($urandom_range(0, 4) < 3),
                  "rand");
        end

        // Address wrap on the high-reset instance
        @(negedge clk);
        rst_hi = 1'b1;
        @(negedge clk);
        check_val("wrap0.pc",  if_pc_hi, 32'hFFFF_FFF8);
        check_val("wrap0.pc4", if_pc_plus4_hi, 32'hFFFF_FFFC);
        @(negedge clk);
        check_val("wrap1.pc",  if_pc_hi, 32'hFFFF_FFFC);
        check_val("wrap1.pc4", if_pc_plus4_hi, 32'h0000_0000);
        check_val("wrap1.instr", if_instr_hi, 32'h5A5A_FFFC);
        @(negedge clk);
        check_val("wrap2.pc",  if_pc_hi, 32'h0000_0000);
        check_val("wrap2.pc4", if_pc_plus4_hi, 32'h0000_0004);
        check_val("wrap2.fcnt", fetch_count_hi, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
